// File: rtl/spy_fifo_pkg.sv
// Shared constants and elaboration helpers for the spy FIFO array.
package spy_fifo_pkg;

    localparam int STATS_W = 16;

    function automatic int chan_sel_w(input int n_chan);
        return (n_chan > 1) ? $clog2(n_chan) : 1;
    endfunction

    // Almost-full margin must leave at least one free slot and be non-zero.
    function automatic bit af_margin_ok(input int af_margin, input int fifo_depth);
        return (af_margin >= 1) && (af_margin <= (1 << fifo_depth) - 1);
    endfunction

endpackage

// File: rtl/spy_fifo_array_if.sv
// Bus bundle for spy_fifo_array; SPY_FIFO_ARRAY_STATS_EN adds the per-channel write counters.
interface spy_fifo_array_if
    import spy_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int N_CHANNELS = 4,
    parameter int SPY_DEPTH  = 8
);
    localparam int CHAN_W = chan_sel_w(N_CHANNELS);

    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] write_data;
    logic [N_CHANNELS-1:0]                 write_enable;
    logic [N_CHANNELS-1:0]                 read_enable;
    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] read_data;
    logic [N_CHANNELS-1:0]                 empty;
    logic [N_CHANNELS-1:0]                 almost_full;
    logic [N_CHANNELS-1:0]                 overflow;
    logic [N_CHANNELS-1:0]                 underflow;
    logic                                  clear_errors;
    logic [N_CHANNELS-1:0]                 freeze;
    logic [CHAN_W-1:0]                     spy_chan;
    logic [SPY_DEPTH-1:0]                  spy_addr;
    logic [DATA_WIDTH-1:0]                 spy_data;
    logic [N_CHANNELS-1:0][SPY_DEPTH-1:0]  spy_wptr;
    logic [N_CHANNELS-1:0]                 spy_wrapped;
`ifdef SPY_FIFO_ARRAY_STATS_EN
    logic [N_CHANNELS-1:0][STATS_W-1:0]    words_in;
    logic [N_CHANNELS-1:0][STATS_W-1:0]    words_dropped;
`endif

    modport master (
        output write_data, write_enable, read_enable, clear_errors, freeze, spy_chan, spy_addr,
        input  read_data, empty, almost_full, overflow, underflow, spy_data, spy_wptr, spy_wrapped
`ifdef SPY_FIFO_ARRAY_STATS_EN
        , input words_in, words_dropped
`endif
    );

    modport slave (
        input  write_data, write_enable, read_enable, clear_errors, freeze, spy_chan, spy_addr,
        output read_data, empty, almost_full, overflow, underflow, spy_data, spy_wptr, spy_wrapped
`ifdef SPY_FIFO_ARRAY_STATS_EN
        , output words_in, words_dropped
`endif
    );

endinterface

// File: rtl/spy_fifo_channel.sv
// One FWFT FIFO with its freezable spy ring and sticky error flags.
// SPY_FIFO_ARRAY_STATS_EN adds saturating accepted/dropped write counters.
module spy_fifo_channel
    import spy_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int FIFO_DEPTH = 6,
    parameter int SPY_DEPTH  = 8,
    parameter int AF_MARGIN  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic                  i_write_enable,
    input  logic                  i_read_enable,
    input  logic                  i_clear_errors,
    input  logic                  i_freeze,
    input  logic [SPY_DEPTH-1:0]  i_spy_addr,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic [SPY_DEPTH-1:0]  o_spy_wptr,
    output logic                  o_spy_wrapped,
    output logic [DATA_WIDTH-1:0] o_spy_rd_data
`ifdef SPY_FIFO_ARRAY_STATS_EN
    ,
    output logic [STATS_W-1:0]    o_words_in,
    output logic [STATS_W-1:0]    o_words_dropped
`endif
);
    localparam int FIFO_ENTRIES = 1 << FIFO_DEPTH;
    localparam int SPY_ENTRIES  = 1 << SPY_DEPTH;
    localparam logic [FIFO_DEPTH:0] FULL_COUNT = (FIFO_DEPTH+1)'(FIFO_ENTRIES);
    localparam logic [FIFO_DEPTH:0] AF_THRESH  = (FIFO_DEPTH+1)'(FIFO_ENTRIES - AF_MARGIN);

    logic [DATA_WIDTH-1:0] r_fifo_mem [FIFO_ENTRIES];
    logic [DATA_WIDTH-1:0] r_spy_mem  [SPY_ENTRIES];
    logic [FIFO_DEPTH-1:0] r_wptr;
    logic [FIFO_DEPTH-1:0] r_rptr;
    logic [FIFO_DEPTH:0]   r_count;
    logic [FIFO_DEPTH:0]   w_count_next;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [SPY_DEPTH-1:0]  r_spy_wptr;
    logic                  r_spy_wrapped;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic                  w_spy_wr;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_pop     = i_read_enable & ~w_empty;
    // A pop in the same cycle frees the slot, so a write at full is still accepted.
    assign w_push    = i_write_enable & (~w_full | w_pop);
    assign w_ovf_evt = i_write_enable & ~w_push;
    assign w_udf_evt = i_read_enable & w_empty;
    assign w_spy_wr  = w_push & ~i_freeze;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_spy_wptr    <= '0;
            r_spy_wrapped <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count       <= w_count_next;
            r_almost_full <= (w_count_next >= AF_THRESH);
            if (w_ovf_evt)           r_overflow  <= 1'b1;
            else if (i_clear_errors) r_overflow  <= 1'b0;
            if (w_udf_evt)           r_underflow <= 1'b1;
            else if (i_clear_errors) r_underflow <= 1'b0;
            if (w_spy_wr) begin
                r_spy_wptr <= r_spy_wptr + 1'b1;
                if (&r_spy_wptr) r_spy_wrapped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push)   r_fifo_mem[r_wptr]    <= i_write_data;
        if (w_spy_wr) r_spy_mem[r_spy_wptr] <= i_write_data;
    end

    assign o_read_data   = w_empty ? '0 : r_fifo_mem[r_rptr];
    assign o_empty       = w_empty;
    assign o_almost_full = r_almost_full;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;
    assign o_spy_wptr    = r_spy_wptr;
    assign o_spy_wrapped = r_spy_wrapped;
    assign o_spy_rd_data = r_spy_mem[i_spy_addr];

`ifdef SPY_FIFO_ARRAY_STATS_EN
    logic [STATS_W-1:0] r_words_in;
    logic [STATS_W-1:0] r_words_dropped;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_words_in      <= '0;
            r_words_dropped <= '0;
        end else if (i_clear_errors) begin
            r_words_in      <= '0;
            r_words_dropped <= '0;
        end else begin
            if (w_push && !(&r_words_in))         r_words_in      <= r_words_in + 1'b1;
            if (w_ovf_evt && !(&r_words_dropped)) r_words_dropped <= r_words_dropped + 1'b1;
        end
    end

    assign o_words_in      = r_words_in;
    assign o_words_dropped = r_words_dropped;
`endif

endmodule

// File: rtl/spy_fifo_array.sv
// N_CHANNELS spy-shadowed FIFOs with a shared registered spy readback port.
// SPY_FIFO_ARRAY_STATS_EN exposes per-channel accepted/dropped write counters.
module spy_fifo_array
    import spy_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int N_CHANNELS = 4,
    parameter int FIFO_DEPTH = 6,
    parameter int SPY_DEPTH  = 8,
    parameter int AF_MARGIN  = 4
) (
    input  logic            clock,
    input  logic            reset,
    spy_fifo_array_if.slave bus
);
    localparam bit AF_MARGIN_VALID = af_margin_ok(AF_MARGIN, FIFO_DEPTH);

    if (!AF_MARGIN_VALID) begin : g_bad_af_margin
        $error("spy_fifo_array: AF_MARGIN must be in 1..2**FIFO_DEPTH-1");
    end

    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] w_read_data;
    logic [N_CHANNELS-1:0]                 w_empty;
    logic [N_CHANNELS-1:0]                 w_almost_full;
    logic [N_CHANNELS-1:0]                 w_overflow;
    logic [N_CHANNELS-1:0]                 w_underflow;
    logic [N_CHANNELS-1:0][SPY_DEPTH-1:0]  w_spy_wptr;
    logic [N_CHANNELS-1:0]                 w_spy_wrapped;
    logic [DATA_WIDTH-1:0]                 w_spy_rd [N_CHANNELS];
    logic [DATA_WIDTH-1:0]                 r_spy_data;
`ifdef SPY_FIFO_ARRAY_STATS_EN
    logic [N_CHANNELS-1:0][STATS_W-1:0]    w_words_in;
    logic [N_CHANNELS-1:0][STATS_W-1:0]    w_words_dropped;
`endif

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        spy_fifo_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .SPY_DEPTH  (SPY_DEPTH),
            .AF_MARGIN  (AF_MARGIN)
        ) u_chan (
            .clock          (clock),
            .reset          (reset),
            .i_write_data   (bus.write_data[g]),
            .i_write_enable (bus.write_enable[g]),
            .i_read_enable  (bus.read_enable[g]),
            .i_clear_errors (bus.clear_errors),
            .i_freeze       (bus.freeze[g]),
            .i_spy_addr     (bus.spy_addr),
            .o_read_data    (w_read_data[g]),
            .o_empty        (w_empty[g]),
            .o_almost_full  (w_almost_full[g]),
            .o_overflow     (w_overflow[g]),
            .o_underflow    (w_underflow[g]),
            .o_spy_wptr     (w_spy_wptr[g]),
            .o_spy_wrapped  (w_spy_wrapped[g]),
            .o_spy_rd_data  (w_spy_rd[g])
`ifdef SPY_FIFO_ARRAY_STATS_EN
            ,
            .o_words_in      (w_words_in[g]),
            .o_words_dropped (w_words_dropped[g])
`endif
        );
    end

    // Sampled before this edge's spy write lands, so a same-address read sees the old word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_spy_data <= '0;
        end else if (int'(bus.spy_chan) < N_CHANNELS) begin
            r_spy_data <= w_spy_rd[bus.spy_chan];
        end else begin
            r_spy_data <= '0;
        end
    end

    assign bus.read_data   = w_read_data;
    assign bus.empty       = w_empty;
    assign bus.almost_full = w_almost_full;
    assign bus.overflow    = w_overflow;
    assign bus.underflow   = w_underflow;
    assign bus.spy_wptr    = w_spy_wptr;
    assign bus.spy_wrapped = w_spy_wrapped;
    assign bus.spy_data    = r_spy_data;
`ifdef SPY_FIFO_ARRAY_STATS_EN
    assign bus.words_in      = w_words_in;
    assign bus.words_dropped = w_words_dropped;
`endif

endmodule
